// File: rtl/ntt_stage_sched.sv
// Butterfly-pair address scheduler for one NTT/INTT ALU lane.
// Walks all LOG_N stages of the transform. Each stage issues N/2 coefficient-pair
// addresses together with the swap select, then waits PIPE_LAT cycles so the ALU
// pipe can empty before the next stage starts reading.
module ntt_stage_sched #(
  parameter int LOG_N      = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int PIPE_LAT   = 8,
  parameter int STAGE_W    = $clog2(LOG_N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_addr0,
  output logic [ADDR_WIDTH-1:0] o_addr1,
  output logic                  o_alu_inout_swap,
  output logic [STAGE_W-1:0]    o_stage,
  output logic                  o_stage_done,
  output logic                  o_done
);

  localparam int J_W  = LOG_N - 1;
  localparam int DC_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_nxt_state;
  logic [J_W-1:0]      r_j, w_nxt_j;
  logic [STAGE_W-1:0]  r_stage, w_nxt_stage;
  logic [DC_W-1:0]     r_dcnt, w_nxt_dcnt;
  logic                r_mode, w_nxt_mode;

  logic                  r_busy, r_valid, r_swap, r_stage_done, r_done;
  logic [ADDR_WIDTH-1:0] r_addr0, r_addr1;

  logic [STAGE_W-1:0]    w_k;
  logic [ADDR_WIDTH-1:0] w_jx, w_mask, w_a0, w_a1;
  logic                  w_swap;

  // Scheduler state register: FSM plus pair, stage and drain counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_j     <= '0;
      r_stage <= '0;
      r_dcnt  <= '0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_j     <= w_nxt_j;
      r_stage <= w_nxt_stage;
      r_dcnt  <= w_nxt_dcnt;
      r_mode  <= w_nxt_mode;
    end
  end

  // Next-state logic; a stalled RUN keeps everything as-is so the outputs hold.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_j     = r_j;
    w_nxt_stage = r_stage;
    w_nxt_dcnt  = r_dcnt;
    w_nxt_mode  = r_mode;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_nxt_state = S_RUN;
          w_nxt_j     = '0;
          w_nxt_stage = '0;
          w_nxt_dcnt  = '0;
          w_nxt_mode  = i_mode;
        end
      end
      S_RUN: begin
        if (i_ready) begin
          if (r_j == {J_W{1'b1}}) begin
            w_nxt_state = S_DRAIN;
            w_nxt_dcnt  = '0;
          end else begin
            w_nxt_j = r_j + J_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (r_dcnt == DC_W'(PIPE_LAT - 1)) begin
          w_nxt_dcnt = '0;
          if (r_stage == STAGE_W'(LOG_N - 1)) begin
            w_nxt_state = S_DONE;
          end else begin
            w_nxt_state = S_RUN;
            w_nxt_stage = r_stage + STAGE_W'(1);
            w_nxt_j     = '0;
          end
        end else begin
          w_nxt_dcnt = r_dcnt + DC_W'(1);
        end
      end
      S_DONE: begin
        w_nxt_state = S_IDLE;
        w_nxt_stage = '0;
        w_nxt_j     = '0;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Pair addresses for the upcoming cycle: a zero bit inserted into j at position k.
  always_comb begin
    w_k    = w_nxt_mode ? w_nxt_stage : (STAGE_W'(LOG_N - 1) - w_nxt_stage);
    w_jx   = ADDR_WIDTH'(w_nxt_j);
    w_mask = (ADDR_WIDTH'(1) << w_k) - ADDR_WIDTH'(1);
    w_a0   = ((w_jx & ~w_mask) << 1) | (w_jx & w_mask);
    w_a1   = w_a0 | (ADDR_WIDTH'(1) << w_k);
    w_swap = (w_k == '0) & w_nxt_j[0];
  end

  // Output registers, loaded from next-state values so they line up with the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_addr0      <= '0;
      r_addr1      <= '0;
      r_swap       <= 1'b0;
      r_stage_done <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_busy       <= (w_nxt_state != S_IDLE);
      r_valid      <= (w_nxt_state == S_RUN);
      r_addr0      <= (w_nxt_state == S_RUN) ? w_a0 : '0;
      r_addr1      <= (w_nxt_state == S_RUN) ? w_a1 : '0;
      r_swap       <= (w_nxt_state == S_RUN) & w_swap;
      r_stage_done <= (w_nxt_state == S_DRAIN) && (w_nxt_dcnt == DC_W'(PIPE_LAT - 1));
      r_done       <= (w_nxt_state == S_DONE);
    end
  end

  assign o_busy           = r_busy;
  assign o_valid          = r_valid;
  assign o_addr0          = r_addr0;
  assign o_addr1          = r_addr1;
  assign o_alu_inout_swap = r_swap;
  assign o_stage          = r_stage;
  assign o_stage_done     = r_stage_done;
  assign o_done           = r_done;

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Directed bench for ntt_stage_sched with LOG_N=4, PIPE_LAT=3.
module tb_ntt_stage_sched;

  localparam int LOG_N = 4;
  localparam int AW    = 4;
  localparam int PL    = 3;
  localparam int SW    = 2;

  logic          clk = 1'b0;
  logic          rst, i_start, i_mode, i_ready;
  logic          o_busy, o_valid, o_alu_inout_swap, o_stage_done, o_done;
  logic [AW-1:0] o_addr0, o_addr1;
  logic [SW-1:0] o_stage;

  int npass = 0;
  int ntot  = 0;

  ntt_stage_sched #(.LOG_N(LOG_N), .ADDR_WIDTH(AW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_ready(i_ready),
    .o_busy(o_busy), .o_valid(o_valid), .o_addr0(o_addr0), .o_addr1(o_addr1),
    .o_alu_inout_swap(o_alu_inout_swap), .o_stage(o_stage),
    .o_stage_done(o_stage_done), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, c, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue check: valid, addr pair, swap
  task automatic chk_pair(input string tag, input int c, input int a0, input int a1, input int sw);
    chk(tag, c, {o_valid, o_alu_inout_swap, 6'd0, 4'(o_addr0), 4'(o_addr1)},
        {1'b1, 1'(sw), 6'd0, 4'(a0), 4'(a1)});
  endtask

  task automatic do_start(input logic mode);
    i_start = 1'b1;
    i_mode  = mode;
    tick();
    i_start = 1'b0;
  endtask

  logic [14:0] w_all;
  assign w_all = {o_busy, o_valid, o_addr0, o_addr1, o_alu_inout_swap, o_stage, o_stage_done, o_done};

  initial begin
    bit saw_done;
    rst = 1'b1; i_start = 1'b0; i_mode = 1'b0; i_ready = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", 0, 32'(w_all), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_outputs", 0, 32'(w_all), 32'd0);

    // NTT, ready high, with a stray start at t0+20
    do_start(1'b0);
    for (int c = 1; c <= 47; c++) begin
      if (c >= 1 && c <= 8) chk_pair("ntt_s0_pair", c, c - 1, c + 7, 0);
      if (c >= 9 && c <= 11) chk("ntt_drain_valid", c, 32'(o_valid), 32'd0);
      if (c == 12) chk("ntt_stage1_idx", c, 32'(o_stage), 32'd1);
      if (c == 12) chk_pair("ntt_s1_first", c, 0, 4, 0);
      if (c == 23) chk_pair("ntt_s2_first", c, 0, 2, 0);
      if (c == 35) chk_pair("ntt_s3_j1", c, 2, 3, 1);
      chk("ntt_stage_done", c, 32'(o_stage_done), 32'(c == 11 || c == 22 || c == 33 || c == 44));
      chk("ntt_done", c, 32'(o_done), 32'(c == 45));
      if (c >= 45) chk("ntt_busy", c, 32'(o_busy), 32'(c == 45));
      i_start = (c == 20);
      tick();
    end

    // INTT; i_mode flips mid-run and must be ignored
    do_start(1'b1);
    for (int c = 1; c <= 46; c++) begin
      if (c == 1) chk_pair("intt_s0_p0", c, 0, 1, 0);
      if (c == 2) chk_pair("intt_s0_p1", c, 2, 3, 1);
      if (c == 3) chk_pair("intt_s0_p2", c, 4, 5, 0);
      if (c == 12) chk_pair("intt_s1_p0", c, 0, 2, 0);
      if (c == 14) chk_pair("intt_s1_p2", c, 4, 6, 0);
      if (c >= 34 && c <= 41) chk_pair("intt_s3_pair", c, c - 34, c - 26, 0);
      chk("intt_done", c, 32'(o_done), 32'(c == 45));
      i_mode = (c < 5);
      tick();
    end

    // NTT with a 5-cycle stall while (2,10) is on the bus
    do_start(1'b0);
    for (int c = 1; c <= 52; c++) begin
      if (c >= 3 && c <= 8) chk_pair("stall_hold", c, 2, 10, 0);
      if (c == 9) chk_pair("stall_next", c, 3, 11, 0);
      if (c >= 40) chk("stall_done", c, 32'(o_done), 32'(c == 50));
      i_ready = !(c >= 3 && c <= 7);
      tick();
    end
    i_ready = 1'b1;

    // reset mid-run at t0+15, then clean restart
    do_start(1'b0);
    saw_done = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 16) chk("midrst_outputs", c, 32'(w_all), 32'd0);
      if (c >= 16 && (o_done || o_stage_done)) saw_done = 1'b1;
      rst = (c == 15);
      tick();
    end
    chk("midrst_no_done", 60, 32'(saw_done), 32'd0);
    do_start(1'b0);
    for (int c = 1; c <= 11; c++) begin
      if (c == 1) chk("restart_stage", c, 32'(o_stage), 32'd0);
      if (c == 1) chk_pair("restart_p0", c, 0, 8, 0);
      chk("restart_sdone", c, 32'(o_stage_done), 32'(c == 11));
      tick();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
